// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch (I) and load/store (D)
// Optional MEM_ARB_RR_EN: round-robin on contention instead of fixed D-over-I priority.
module mem_port_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic              d_byte,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic              mem_byte,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              grant_d_q;
   logic              cmd_zero_q;
   logic              cmd_err_q;
   logic              i_ack_q, d_ack_q, d_err_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              mem_read_q, mem_write_q, mem_byte_q;
   logic              pick_d;
   logic              d_misalign;

   assign d_misalign = !d_byte && (d_addr[1:0] != 2'b00);

`ifdef MEM_ARB_RR_EN
   logic last_grant_q;  // 1 = D was granted last
   assign pick_d = d_req && (!i_req || !last_grant_q);
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grant_d_q   <= 1'b0;
         cmd_zero_q  <= 1'b0;
         cmd_err_q   <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         d_err_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_byte_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_grant_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               if (d_req || i_req) begin
                  state_q   <= ACCESS;
                  cnt_q     <= 4'(WAIT_STATES);
                  grant_d_q <= pick_d;
`ifdef MEM_ARB_RR_EN
                  last_grant_q <= pick_d;
`endif
                  if (pick_d) begin
                     mem_addr_q  <= d_addr;
                     mem_wdata_q <= d_wdata;
                     mem_byte_q  <= d_byte;
                     // misaligned word ops run the full window with strobes suppressed
                     mem_read_q  <= !d_we && !d_misalign;
                     mem_write_q <= d_we && !d_misalign;
                     cmd_zero_q  <= d_we || d_misalign;
                     cmd_err_q   <= d_misalign;
                     d_err_q     <= 1'b0;
                  end else begin
                     mem_addr_q  <= i_addr;
                     mem_wdata_q <= '0;
                     mem_byte_q  <= 1'b0;
                     mem_read_q  <= 1'b1;
                     mem_write_q <= 1'b0;
                     cmd_zero_q  <= 1'b0;
                     cmd_err_q   <= 1'b0;
                  end
               end
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  state_q     <= DONE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_byte_q  <= 1'b0;
                  if (grant_d_q) begin
                     d_ack_q <= 1'b1;
                     d_err_q <= cmd_err_q;
                     if (cmd_zero_q)
                        d_rdata_q <= '0;
                     else if (mem_byte_q)
                        d_rdata_q <= {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
                     else
                        d_rdata_q <= mem_rdata;
                  end else begin
                     i_ack_q   <= 1'b1;
                     i_rdata_q <= mem_rdata;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_ack     = i_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_ack     = d_ack_q;
   assign d_rdata   = d_rdata_q;
   assign d_err     = d_err_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_byte  = mem_byte_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, d_req, d_we, d_byte;
   logic [17:0] i_addr, d_addr;
   logic [31:0] d_wdata;
   logic        i_ack, d_ack, d_err;
   logic [31:0] i_rdata, d_rdata;
   logic [17:0] mem_addr;
   logic [31:0] mem_wdata, mem_rdata;
   logic        mem_read, mem_write, mem_byte;

   logic        w_i_req;
   logic [17:0] w_i_addr;
   logic        w_i_ack, w_d_ack, w_d_err;
   logic [31:0] w_i_rdata, w_d_rdata;
   logic [17:0] w_mem_addr;
   logic [31:0] w_mem_wdata, w_mem_rdata;
   logic        w_mem_read, w_mem_write, w_mem_byte;

   logic [31:0] mem [0:255];
   logic        pre_we;
   logic [7:0]  pre_idx;
   logic [31:0] pre_val;
   logic [31:0] rd_word;

   int total = 0;
   int bad   = 0;

`ifdef MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_STATES(0)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_byte(mem_byte), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(18), .DATA_W(32), .WAIT_STATES(3)) u_dut_ws3 (
      .clk(clk), .reset(reset),
      .i_req(w_i_req), .i_addr(w_i_addr), .i_ack(w_i_ack), .i_rdata(w_i_rdata),
      .d_req(1'b0), .d_we(1'b0), .d_byte(1'b0), .d_addr(18'h0), .d_wdata(32'h0),
      .d_ack(w_d_ack), .d_rdata(w_d_rdata), .d_err(w_d_err),
      .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_read(w_mem_read),
      .mem_write(w_mem_write), .mem_byte(w_mem_byte), .mem_rdata(w_mem_rdata)
   );

   // byte-lane memory model; byte reads come back zero-extended in [7:0]
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_idx] <= pre_val;
      else if (mem_write) begin
         if (mem_byte)
            mem[mem_addr[9:2]][8*mem_addr[1:0] +: 8] <= mem_wdata[7:0];
         else
            mem[mem_addr[9:2]] <= mem_wdata;
      end
   end

   always_comb begin
      rd_word   = mem[mem_addr[9:2]];
      mem_rdata = mem_byte ? {24'h0, rd_word[8*mem_addr[1:0] +: 8]} : rd_word;
   end

   assign w_mem_rdata = 32'hA5A50000 | {14'h0, w_mem_addr};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] val);
      pre_we = 1'b1; pre_idx = idx; pre_val = val;
      tick();
      pre_we = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      i_req = 0; d_req = 0; d_we = 0; d_byte = 0; i_addr = 0; d_addr = 0; d_wdata = 0;
      w_i_req = 0; w_i_addr = 0; pre_we = 0; pre_idx = 0; pre_val = 0;
      tick(); tick();
      preload(8'd4, 32'hDEADBEEF);
      preload(8'd8, 32'h11223344);
      preload(8'd1, 32'h0BADF00D);
      total++; if ({i_ack, d_ack, d_err, mem_read, mem_write, mem_byte} !== 6'b0) begin
         bad++; $display("FAIL reset_flags got=%b exp=000000", {i_ack, d_ack, d_err, mem_read, mem_write, mem_byte}); end
      total++; if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== '0) begin
         bad++; $display("FAIL reset_data got addr=%h wdata=%h ird=%h drd=%h exp=0", mem_addr, mem_wdata, i_rdata, d_rdata); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_i_read;
      i_req = 1; i_addr = 18'h10;
      tick();
      total++; if ({mem_read, mem_write, i_ack} !== 3'b100 || mem_addr !== 18'h10) begin
         bad++; $display("FAIL i_read_strobe got rd/wr/ack=%b addr=%h exp=100 addr=10", {mem_read, mem_write, i_ack}, mem_addr); end
      tick();
      total++; if ({i_ack, d_ack, mem_read} !== 3'b100) begin
         bad++; $display("FAIL i_read_ack got iack/dack/rd=%b exp=100", {i_ack, d_ack, mem_read}); end
      total++; if (i_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL i_read_data got=%h exp=deadbeef", i_rdata); end
      i_req = 0;
      tick();
      total++; if (i_ack !== 1'b0 || i_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL i_read_hold got ack=%b data=%h exp ack=0 data=deadbeef", i_ack, i_rdata); end
   endtask

   task automatic test_byte_ops;
      d_req = 1; d_we = 1; d_byte = 1; d_addr = 18'h21; d_wdata = 32'h123456AB;
      tick();
      total++; if ({mem_write, mem_byte, mem_read} !== 3'b110 || mem_addr !== 18'h21 || mem_wdata[7:0] !== 8'hAB) begin
         bad++; $display("FAIL sb_strobe got wr/byte/rd=%b addr=%h wd=%h exp=110 addr=21 wd[7:0]=ab", {mem_write, mem_byte, mem_read}, mem_addr, mem_wdata); end
      tick();
      total++; if ({d_ack, d_err, i_ack, mem_write} !== 4'b1000 || d_rdata !== 32'h0) begin
         bad++; $display("FAIL sb_ack got dack/err/iack/wr=%b rdata=%h exp=1000 rdata=0", {d_ack, d_err, i_ack, mem_write}, d_rdata); end
      d_req = 0;
      tick();
      d_req = 1; d_we = 0; d_byte = 1; d_addr = 18'h21;
      tick();
      total++; if ({mem_read, mem_byte, mem_write} !== 3'b110) begin
         bad++; $display("FAIL lb_strobe got rd/byte/wr=%b exp=110", {mem_read, mem_byte, mem_write}); end
      tick();
      total++; if (d_ack !== 1'b1 || d_rdata !== 32'h000000AB) begin
         bad++; $display("FAIL lb_data got ack=%b data=%h exp ack=1 data=000000ab", d_ack, d_rdata); end
      d_req = 0;
      tick();
   endtask

   task automatic test_contention;
      i_req = 1; i_addr = 18'h10;
      d_req = 1; d_we = 0; d_byte = 0; d_addr = 18'h20;
      tick();
      total++; if (mem_addr !== 18'h20) begin
         bad++; $display("FAIL cont1_grant got addr=%h exp=20", mem_addr); end
      tick();
      total++; if ({d_ack, i_ack} !== 2'b10 || d_rdata !== 32'h1122AB44) begin
         bad++; $display("FAIL cont1_dack got d/i=%b data=%h exp=10 data=1122ab44", {d_ack, i_ack}, d_rdata); end
      d_req = 0;
      tick();
      total++; if ({d_ack, i_ack, mem_read} !== 3'b000) begin
         bad++; $display("FAIL cont1_idle got d/i/rd=%b exp=000", {d_ack, i_ack, mem_read}); end
      tick();
      total++; if (mem_addr !== 18'h10 || mem_read !== 1'b1) begin
         bad++; $display("FAIL cont1_igrant got addr=%h rd=%b exp addr=10 rd=1", mem_addr, mem_read); end
      tick();
      total++; if ({d_ack, i_ack} !== 2'b01 || i_rdata !== 32'hDEADBEEF || d_rdata !== 32'h1122AB44) begin
         bad++; $display("FAIL cont1_iack got d/i=%b ird=%h drd=%h exp=01 deadbeef 1122ab44", {d_ack, i_ack}, i_rdata, d_rdata); end
      i_req = 0;
      tick();
   endtask

   task automatic test_misaligned;
      d_req = 1; d_we = 1; d_byte = 0; d_addr = 18'h6; d_wdata = 32'hFFFFFFFF;
      tick();
      total++; if ({mem_write, mem_read} !== 2'b00) begin
         bad++; $display("FAIL mis_strobe got wr/rd=%b exp=00", {mem_write, mem_read}); end
      tick();
      total++; if ({d_ack, d_err, mem_write} !== 3'b110 || d_rdata !== 32'h0) begin
         bad++; $display("FAIL mis_ack got ack/err/wr=%b rdata=%h exp=110 rdata=0", {d_ack, d_err, mem_write}, d_rdata); end
      d_req = 0;
      tick();
      total++; if (mem[1] !== 32'h0BADF00D) begin
         bad++; $display("FAIL mis_memory got=%h exp=0badf00d", mem[1]); end
   endtask

   task automatic test_back_to_back;
      // last grant was D, so round-robin favours I here
      logic [17:0] first_addr;
      first_addr = RR ? 18'h10 : 18'h20;
      i_req = 1; i_addr = 18'h10;
      d_req = 1; d_we = 0; d_byte = 0; d_addr = 18'h20;
      tick();
      total++; if (mem_addr !== first_addr || d_err !== 1'b0) begin
         bad++; $display("FAIL cont2_grant got addr=%h err=%b exp addr=%h err=0", mem_addr, d_err, first_addr); end
      tick();
      total++; if ({d_ack, i_ack} !== (RR ? 2'b01 : 2'b10)) begin
         bad++; $display("FAIL cont2_first got d/i=%b exp=%b", {d_ack, i_ack}, RR ? 2'b01 : 2'b10); end
      if (RR) i_req = 0; else d_req = 0;
      tick(); tick(); tick();
      total++; if ({d_ack, i_ack} !== (RR ? 2'b10 : 2'b01)) begin
         bad++; $display("FAIL cont2_second got d/i=%b exp=%b", {d_ack, i_ack}, RR ? 2'b10 : 2'b01); end
      total++; if (d_rdata !== 32'h1122AB44 || d_err !== 1'b0) begin
         bad++; $display("FAIL cont2_ddata got data=%h err=%b exp 1122ab44 err=0", d_rdata, d_err); end
      i_req = 0; d_req = 0;
      tick();
   endtask

   task automatic test_wait_states;
      w_i_req = 1; w_i_addr = 18'h40;
      tick();
      for (int k = 0; k < 4; k++) begin
         total++; if ({w_mem_read, w_i_ack} !== 2'b10) begin
            bad++; $display("FAIL ws3_access%0d got rd/ack=%b exp=10", k, {w_mem_read, w_i_ack}); end
         tick();
      end
      total++; if ({w_mem_read, w_i_ack} !== 2'b01 || w_i_rdata !== 32'hA5A50040) begin
         bad++; $display("FAIL ws3_ack got rd/ack=%b data=%h exp=01 data=a5a50040", {w_mem_read, w_i_ack}, w_i_rdata); end
      w_i_req = 0;
      tick();
   endtask

   task automatic test_reset_mid_access;
      d_req = 1; d_we = 1; d_byte = 0; d_addr = 18'h30; d_wdata = 32'h55AA55AA;
      tick();
      total++; if (mem_write !== 1'b1) begin
         bad++; $display("FAIL rst_pre_write got=%b exp=1", mem_write); end
      reset = 1;
      tick();
      total++; if ({mem_write, d_ack} !== 2'b00) begin
         bad++; $display("FAIL rst_abort got wr/ack=%b exp=00", {mem_write, d_ack}); end
      reset = 0; d_req = 0;
      tick();
      total++; if ({mem_write, mem_read, d_ack, i_ack} !== 4'b0000) begin
         bad++; $display("FAIL rst_quiet got wr/rd/dack/iack=%b exp=0000", {mem_write, mem_read, d_ack, i_ack}); end
      i_req = 1; i_addr = 18'h10;
      tick(); tick();
      total++; if (i_ack !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rst_idle_restart got ack=%b data=%h exp ack=1 data=deadbeef", i_ack, i_rdata); end
      i_req = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_i_read();
      test_byte_ops();
      test_contention();
      test_misaligned();
      test_back_to_back();
      test_wait_states();
      test_reset_mid_access();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
